// File: rtl/sr_target_if.sv
// Serial configuration chain bus between a chain master and an sr_target.
// The master drives clock, data and load; the target returns readback data.
interface sr_target_if;
  logic clk_sr;
  logic din_sr;
  logic load_sr;
  logic dout_sr;

  modport master (output clk_sr, output din_sr, output load_sr, input dout_sr);
  modport slave  (input clk_sr, input din_sr, input load_sr, output dout_sr);
endinterface

// File: rtl/sr_target.sv
// Serial configuration chain target: shifts in a WIDTH-bit word from an
// asynchronous master and commits it to cfg on load if the bit count is exact.
module sr_target #(
  parameter int WIDTH = 170,
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  sr_target_if.slave       sr,
  input  logic [WIDTH-1:0] status_in,
  output logic [WIDTH-1:0] cfg,
  output logic             cfg_valid,
  output logic             frame_err
);

  logic [1:0]       clk_sync;
  logic [1:0]       din_sync;
  logic [1:0]       load_sync;
  logic             clk_hist;
  logic             load_hist;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] bitcnt;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             shift_ev;
  logic             load_ev;
  logic             din_s;

  // Events stay masked until the synchronizers and history flops have all
  // seen real pin values, so a line already high at reset release is ignored.
  assign armed    = (arm_cnt == 2'd0);
  assign shift_ev = armed & clk_sync[1] & ~clk_hist;
  assign load_ev  = armed & load_sync[1] & ~load_hist;
  assign din_s    = din_sync[1];

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      clk_sync   <= '0;
      din_sync   <= '0;
      load_sync  <= '0;
      clk_hist   <= 1'b0;
      load_hist  <= 1'b0;
      sreg       <= '0;
      bitcnt     <= '0;
      arm_cnt    <= 2'd3;
      cfg        <= '0;
      cfg_valid  <= 1'b0;
      frame_err  <= 1'b0;
      sr.dout_sr <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], sr.clk_sr};
      din_sync   <= {din_sync[0], sr.din_sr};
      load_sync  <= {load_sync[0], sr.load_sr};
      clk_hist   <= clk_sync[1];
      load_hist  <= load_sync[1];
      cfg_valid  <= 1'b0;
      sr.dout_sr <= sreg[WIDTH-1];
      if (!armed)
        arm_cnt <= arm_cnt - 2'd1;

      // Load has priority; a coincident shift is dropped so cfg gets pre-shift sreg.
      if (load_ev) begin
        if (bitcnt == CNT_W'(WIDTH)) begin
          cfg       <= sreg;
          cfg_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
        sreg   <= status_in;
        bitcnt <= '0;
      end else if (shift_ev) begin
        sreg <= {sreg[WIDTH-2:0], din_s};
        if (bitcnt != {CNT_W{1'b1}})
          bitcnt <= bitcnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sr_target.sv
// Directed bench for sr_target: a scoreboard queue holds expected cfg words,
// popped by a monitor on every cfg_valid pulse.
module tb_sr_target;

  logic         clk_in;
  logic         rst;
  logic [169:0] status_in;
  logic [169:0] cfg;
  logic         cfg_valid;
  logic         frame_err;

  sr_target_if sr_bus ();

  sr_target #(.WIDTH(170), .CNT_W(8)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .sr        (sr_bus),
    .status_in (status_in),
    .cfg       (cfg),
    .cfg_valid (cfg_valid),
    .frame_err (frame_err)
  );

  int checks = 0;
  int errors = 0;
  logic [169:0] exp_q[$];

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (rst && cfg_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cfg_valid_unexpected: got pulse with cfg=%h, required no pulse", cfg);
      end else begin
        logic [169:0] e;
        e = exp_q.pop_front();
        if (cfg !== e) begin
          errors++;
          $display("FAIL cfg_on_valid: got %h required %h", cfg, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b required %0b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [169:0] act, input logic [169:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic shift_bit(input logic b, input logic chk, input logic exp_dout);
    sr_bus.din_sr = b;
    cyc(2);
    if (chk) check_bit("dout_sr", sr_bus.dout_sr, exp_dout);
    sr_bus.clk_sr = 1'b1;
    cyc(3);
    sr_bus.clk_sr = 1'b0;
    cyc(3);
  endtask

  task automatic send_word(input logic [169:0] v);
    for (int i = 169; i >= 0; i--) shift_bit(v[i], 1'b0, 1'b0);
  endtask

  task automatic send_n(input int n, input logic b);
    for (int i = 0; i < n; i++) shift_bit(b, 1'b0, 1'b0);
  endtask

  task automatic do_load();
    sr_bus.load_sr = 1'b1;
    cyc(3);
    sr_bus.load_sr = 1'b0;
    cyc(4);
  endtask

  logic [169:0] f1, f2, f3, f4, f5;

  initial begin
    f1 = {1'b1, 169'd11};
    f2 = 170'h1_2345_6789_abcd_ef01_2345_6789_abcd_ef01_2345;
    f3 = ~f2;
    f4 = {f2[84:0], f2[169:85]};
    f5 = f1 ^ f3;

    rst           = 1'b0;
    sr_bus.clk_sr = 1'b0;
    sr_bus.din_sr = 1'b0;
    sr_bus.load_sr = 1'b0;
    status_in     = '0;
    cyc(3);
    check_vec("reset_cfg", cfg, '0);
    check_bit("reset_cfg_valid", cfg_valid, 1'b0);
    check_bit("reset_frame_err", frame_err, 1'b0);
    check_bit("reset_dout", sr_bus.dout_sr, 1'b0);
    rst = 1'b1;
    cyc(5);

    // Good frame; status 3 is loaded into the chain for readback.
    send_word(f1);
    status_in = 170'h3;
    exp_q.push_back(f1);
    do_load();
    check_vec("good_frame_cfg", cfg, f1);
    check_bit("good_frame_err", frame_err, 1'b0);

    // Readback: 168 zeros then 1,1 while shifting in zeros.
    status_in = f4;
    for (int i = 1; i <= 170; i++) shift_bit(1'b0, 1'b1, (i >= 169));
    exp_q.push_back('0);
    do_load();
    check_vec("zero_frame_cfg", cfg, '0);

    // Shift and load rising together: load wins, cfg takes pre-shift sreg.
    send_word(f2);
    sr_bus.din_sr = 1'b1;
    cyc(2);
    exp_q.push_back(f2);
    sr_bus.clk_sr  = 1'b1;
    sr_bus.load_sr = 1'b1;
    cyc(3);
    sr_bus.clk_sr  = 1'b0;
    sr_bus.load_sr = 1'b0;
    cyc(4);
    check_vec("collide_cfg", cfg, f2);
    send_word(f3);
    exp_q.push_back(f3);
    do_load();
    check_vec("after_collide_cfg", cfg, f3);
    check_bit("after_collide_err", frame_err, 1'b0);

    // Short frame: rejected and sticky error, then a good frame still commits.
    send_n(169, 1'b1);
    do_load();
    check_vec("short_cfg_kept", cfg, f3);
    check_bit("short_frame_err", frame_err, 1'b1);
    send_word(f4);
    exp_q.push_back(f4);
    do_load();
    check_vec("good_after_err_cfg", cfg, f4);
    check_bit("err_sticky", frame_err, 1'b1);

    // Reset mid-frame with clk_sr and load_sr both high across release.
    send_n(80, 1'b1);
    sr_bus.clk_sr  = 1'b1;
    sr_bus.load_sr = 1'b1;
    rst = 1'b0;
    #1;
    check_vec("async_reset_cfg", cfg, '0);
    check_bit("async_reset_err", frame_err, 1'b0);
    cyc(3);
    rst = 1'b1;
    cyc(6);
    sr_bus.clk_sr  = 1'b0;
    sr_bus.load_sr = 1'b0;
    cyc(4);
    check_bit("no_event_at_release", frame_err, 1'b0);
    send_word(f5);
    exp_q.push_back(f5);
    do_load();
    check_vec("post_reset_cfg", cfg, f5);
    check_bit("post_reset_err", frame_err, 1'b0);

    // Overlong frames: counter saturates and never wraps back to 170.
    send_n(300, 1'b1);
    do_load();
    check_vec("long300_cfg", cfg, f5);
    check_bit("long300_err", frame_err, 1'b1);
    send_n(426, 1'b0);
    do_load();
    check_vec("long426_cfg", cfg, f5);

    cyc(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_cfg_valid: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
